// File: rtl/vga_fb_pkg.sv
// Shared constants, types and address helper for the VGA framebuffer path.
// FB_W x FB_H framebuffer of 3-bit pixels, upscaled by SCALE on each axis.
package vga_fb_pkg;

    localparam int unsigned FB_W       = 160;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned SCALE      = 4;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DISP_LINES = FB_H * SCALE;

    typedef logic [ADDR_W-1:0] fb_addr_t;
    typedef logic [2:0]        rgb_t;

    // Linear framebuffer address; y*160 built from two shifts, all at ADDR_W bits.
    function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [6:0] y);
        fb_addr_t yw;
        yw = fb_addr_t'(y);
        return (yw << 7) + (yw << 5) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Writer request channel and single-port RAM bus of the framebuffer arbiter.
//   i_wr_valid/i_wr_x/i_wr_y/i_wr_rgb : writer request, o_wr_ready : grant
//   o_mem_addr/o_mem_we/o_mem_wdata   : RAM command, i_mem_rdata : read data (1-cycle latency)
// slave  = arbiter side, master = writer/RAM environment side.
interface vga_fb_arbiter_if;
    import vga_fb_pkg::*;

    logic       i_wr_valid;
    logic [7:0] i_wr_x;
    logic [6:0] i_wr_y;
    rgb_t       i_wr_rgb;
    logic       o_wr_ready;
    fb_addr_t   o_mem_addr;
    logic       o_mem_we;
    rgb_t       o_mem_wdata;
    rgb_t       i_mem_rdata;

    modport slave (
        input  i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_mem_rdata,
        output o_wr_ready, o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_mem_rdata,
        input  o_wr_ready, o_mem_addr, o_mem_we, o_mem_wdata
    );

endinterface

// File: rtl/vga_pix_fifo.sv
// Two-entry, 3-bit scanout pixel FIFO with a one-deep in-flight reservation.
//   clk, rst_n : clock, async active-low reset
//   reserve    : a RAM read was issued this cycle; its data arrives next cycle
//   wdata      : RAM read data, pushed the cycle after a reservation
//   pop        : consume head (ignored when empty)
//   flush      : drop all entries and any read in flight
//   head       : current head pixel, 0 when empty
//   empty, count, inflight : status; occupancy = count + inflight
module vga_pix_fifo
    import vga_fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reserve,
    input  rgb_t       wdata,
    input  logic       pop,
    input  logic       flush,
    output rgb_t       head,
    output logic       empty,
    output logic [1:0] count,
    output logic       inflight
);

    rgb_t e0;
    rgb_t e1;
    logic push_ok;
    logic pop_ok;

    assign push_ok = inflight;
    assign pop_ok  = pop && (count != 2'd0);
    assign empty   = (count == 2'd0);
    assign head    = empty ? '0 : e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0       <= '0;
            e1       <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            // A datum returning in the flush cycle is discarded with the rest.
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= reserve;
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) e0 <= wdata;
                    else               e1 <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= wdata;
                    end else begin
                        e0 <= e1;
                        e1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter and scanout sequencer. Shares one single-port RAM between
// scanout reads (priority) and a drawing writer, and upscales each framebuffer
// pixel to SCALE x SCALE display pixels.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_pix_ce             : pixel enable
//   i_hblank, i_vblank   : blanking from the timing generators
//   o_rgb                : pixel out, 0 when blanked
//   o_underrun           : sticky, scanout popped an empty FIFO
//   bus                  : writer channel and RAM bus (slave modport)
module vga_fb_arbiter #(
    parameter int unsigned FB_W  = vga_fb_pkg::FB_W,
    parameter int unsigned FB_H  = vga_fb_pkg::FB_H,
    parameter int unsigned SCALE = vga_fb_pkg::SCALE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_ce,
    input  logic              i_hblank,
    input  logic              i_vblank,
    output logic [2:0]        o_rgb,
    output logic              o_underrun,
    vga_fb_arbiter_if.slave   bus
);
    import vga_fb_pkg::*;

    localparam int unsigned SX_W = $clog2(SCALE);

    logic            hblank_d;
    logic            armed;
    logic [8:0]      ln;
    logic [7:0]      fc;
    logic [6:0]      fr;
    logic [SX_W-1:0] sx;

    logic            flush;
    logic            scan;
    logic            rd_issue;
    logic            grant;
    logic            wr_in_range;
    logic            wr_fire;
    logic            pop;

    rgb_t            fifo_head;
    logic            fifo_empty;
    logic [1:0]      fifo_count;
    logic            fifo_inflight;
    logic [1:0]      occ;

    assign flush = i_hblank && !hblank_d;
    // After a mid-line reset nothing is shown until a line or frame boundary
    // re-aligns the column counter with the raster.
    assign scan  = !i_hblank && !i_vblank && armed;
    assign fr    = 7'(ln >> SX_W);
    assign occ   = fifo_count + {1'b0, fifo_inflight};

    assign rd_issue    = armed && !i_vblank && (fc < 8'(FB_W)) && (occ < 2'd2) && !flush;
    assign grant       = i_rst_n && !rd_issue;
    assign wr_in_range = (bus.i_wr_x < 8'(FB_W)) && (bus.i_wr_y < 7'(FB_H));
    assign wr_fire     = bus.i_wr_valid && grant && wr_in_range;
    assign pop         = scan && i_pix_ce && (sx == '1);

    assign bus.o_wr_ready  = grant;
    assign bus.o_mem_we    = wr_fire;
    assign bus.o_mem_wdata = wr_fire ? bus.i_wr_rgb : '0;
    assign bus.o_mem_addr  = rd_issue ? fb_addr(fc, fr) :
                             wr_fire  ? fb_addr(bus.i_wr_x, bus.i_wr_y) : '0;

    assign o_rgb = scan ? fifo_head : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hblank_d   <= 1'b0;
            armed      <= 1'b0;
            ln         <= '0;
            fc         <= '0;
            sx         <= '0;
            o_underrun <= 1'b0;
        end else begin
            hblank_d <= i_hblank;
            if (flush || i_vblank) armed <= 1'b1;

            if (i_vblank)  ln <= '0;
            else if (flush) ln <= (ln == 9'(DISP_LINES - 1)) ? '0 : ln + 9'd1;

            if (flush)         fc <= '0;
            else if (rd_issue) fc <= fc + 8'd1;

            if (!scan)         sx <= '0;
            else if (i_pix_ce) sx <= sx + SX_W'(1);

            if (pop && fifo_empty) o_underrun <= 1'b1;
        end
    end

    vga_pix_fifo u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .reserve  (rd_issue),
        .wdata    (bus.i_mem_rdata),
        .pop      (pop),
        .flush    (flush),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .inflight (fifo_inflight)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: drives a compressed VGA raster, a random writer and
// a 1-cycle-latency RAM model; checks every cycle against a raster-level model.
module tb_vga_fb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_ce;
    logic       hblank;
    logic       vblank;
    logic [2:0] rgb;
    logic       underrun;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(.FB_W(160), .FB_H(120), .SCALE(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pix_ce   (pix_ce),
        .i_hblank   (hblank),
        .i_vblank   (vblank),
        .o_rgb      (rgb),
        .o_underrun (underrun),
        .bus        (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference raster state
    int b_ln      = 0;
    int exp_col   = 0;
    int p         = 0;
    bit prev_hb   = 1'b0;
    bit disp_line = 1'b0;
    bit exp_under = 1'b0;
    bit wr_rand   = 1'b0;

    function automatic logic [2:0] pat(input int c, input int r);
        return 3'((c + r) % 8);
    endfunction

    // RAM model: preloaded pattern, synchronous write, registered read.
    logic [2:0] ram [0:19199];
    initial begin
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++)
                ram[r*160 + c] = pat(c, r);
        bus.i_mem_rdata <= 3'd0;
        forever begin
            @(posedge clk);
            bus.i_mem_rdata <= ram[bus.o_mem_addr];
            if (bus.o_mem_we) ram[bus.o_mem_addr] = bus.o_mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit inr;
        bit set_under;
        set_under = 1'b0;
        if (wr_rand) begin
            bus.i_wr_valid = ($urandom_range(0, 3) != 0);
            bus.i_wr_x     = 8'($urandom_range(0, 200));
            bus.i_wr_y     = 7'($urandom_range(100, 127));
            bus.i_wr_rgb   = 3'($urandom);
        end
        if (!rst_n) begin
            b_ln = 0; exp_col = 0; p = 0; exp_under = 1'b0; disp_line = 1'b0;
        end else begin
            if (hblank && !prev_hb) begin
                if (disp_line) check("reads_per_line", exp_col, 160);
                disp_line = 1'b0;
                exp_col   = 0;
                b_ln      = vblank ? 0 : (b_ln + 1) % 480;
            end
            if (vblank) b_ln = 0;
            else        disp_line = 1'b1;
        end

        @(negedge clk);
        if (!rst_n) begin
            check("rst_rgb", rgb, 0);
            check("rst_underrun", underrun, 0);
            check("rst_ready", bus.o_wr_ready, 0);
            check("rst_we", bus.o_mem_we, 0);
            check("rst_addr", bus.o_mem_addr, 0);
        end else begin
            if (vblank) check("grant_in_vblank", bus.o_wr_ready, 1);
            if (!bus.o_wr_ready) begin
                check("read_addr", bus.o_mem_addr, (b_ln / 4) * 160 + exp_col);
                check("read_no_we", bus.o_mem_we, 0);
                exp_col++;
            end else if (bus.i_wr_valid) begin
                inr = (bus.i_wr_x < 160) && (bus.i_wr_y < 120);
                check("wr_we", bus.o_mem_we, inr);
                if (inr) begin
                    check("wr_addr", bus.o_mem_addr, bus.i_wr_y * 160 + bus.i_wr_x);
                    check("wr_data", bus.o_mem_wdata, bus.i_wr_rgb);
                end
            end else begin
                check("idle_we", bus.o_mem_we, 0);
            end
            if (hblank || vblank) begin
                check("rgb_blank", rgb, 0);
                p = 0;
            end else if (pix_ce) begin
                check("rgb_pix", rgb, (p / 4 < 160) ? pat(p / 4, b_ln / 4) : 3'd0);
                if ((p % 4 == 3) && (p / 4 >= 160)) set_under = 1'b1;
                p++;
            end
            check("underrun", underrun, exp_under);
            if (set_under) exp_under = 1'b1;
        end
        @(posedge clk);
        prev_hb = rst_n ? hblank : 1'b0;
        #1;
    endtask

    task automatic line(input int n_hb, input int n_act, input bit vb);
        hblank = 1'b1;
        for (int i = 0; i < n_hb; i++) begin
            if (i == 1) vblank = vb;
            pix_ce = 1'b1; tick();
            pix_ce = 1'b0; tick();
        end
        hblank = 1'b0;
        for (int i = 0; i < n_act; i++) begin
            pix_ce = 1'b1; tick();
            pix_ce = 1'b0; tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        hblank = 1'b0;
        vblank = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_x     = 8'd10;
        bus.i_wr_y     = 7'd10;
        bus.i_wr_rgb   = 3'd3;
        #1;
        repeat (5) tick();

        rst_n = 1'b1;
        bus.i_wr_x = 8'd159; bus.i_wr_y = 7'd119; bus.i_wr_rgb = 3'd5;
        tick();
        bus.i_wr_x = 8'd160; bus.i_wr_y = 7'd0;   bus.i_wr_rgb = 3'd2;
        tick();
        bus.i_wr_x = 8'd0;   bus.i_wr_y = 7'd120; bus.i_wr_rgb = 3'd7;
        tick();

        wr_rand = 1'b1;
        line(170, 640, 1'b1);
        line(170, 640, 1'b1);
        line(170, 640, 1'b0);   // ln 0
        line(170, 640, 1'b0);   // ln 1
        line(170, 640, 1'b0);   // ln 2
        line(170, 640, 1'b0);   // ln 3, row 0
        line(170, 660, 1'b0);   // ln 4, row 1, overlong -> underrun
        line(4, 0, 1'b1);

        wr_rand = 1'b0;
        bus.i_wr_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
